// File: rtl/jk_seq_pkg.sv
// Shared types for the JK op sequencer: op encoding, FSM states, FIFO entry.
// Entry count field is sized for the widest supported repeat count.
package jk_seq_pkg;

    localparam int CNT_W_MAX = 16;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } jk_state_e;

    typedef struct packed {
        jk_op_e                 op;
        logic [CNT_W_MAX-1:0]   count;
    } jk_entry_t;

    function automatic logic jk_next_q(input logic q, input jk_op_e op);
        logic nq;
        nq = q;
        unique case (op)
            OP_HOLD:   nq = q;
            OP_RESET:  nq = 1'b0;
            OP_SET:    nq = 1'b1;
            OP_TOGGLE: nq = ~q;
            default:   nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_seq_fifo.sv
// Synchronous op FIFO; push is ignored while full, pop ignored while empty.
// Pointers carry one extra wrap bit to tell full from empty.
module jk_seq_fifo
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  jk_entry_t wdata,
    output jk_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    jk_entry_t   mem_q [DEPTH];
    jk_entry_t   mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/jk_op_sequencer.sv
// Queues JK ops and replays each for count+1 cycles, tracking expected q.
// Optional feedback compare enabled by defining JK_SEQ_CHECK_EN.
module jk_op_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [CNT_W-1:0] in_count,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             q_exp
`ifdef JK_SEQ_CHECK_EN
   ,input  logic             q_fb,
    output logic             mismatch
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    jk_state_e        state_q, state_d;
    jk_op_e           op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_exp_q, q_exp_d;

    jk_entry_t        wr_entry;
    jk_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             done_c;
    jk_op_e           jk_drive;
    logic             unused_cnt_hi;

    assign wr_entry = '{op: jk_op_e'(in_op), count: CNT_W_MAX'(in_count)};
    assign push     = in_valid && !fifo_full;
    assign in_ready = !fifo_full;

    jk_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Upper bits of the stored count are always zero for CNT_W < CNT_W_MAX.
    assign unused_cnt_hi = ^head.count;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    op_d    = head.op;
                    cnt_d   = head.count[CNT_W-1:0];
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    done_c = 1'b1;
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        op_d  = head.op;
                        cnt_d = head.count[CNT_W-1:0];
                    end else begin
                        op_d    = OP_HOLD;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                op_d    = OP_HOLD;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign jk_drive = (state_q == ST_DRIVE) ? op_q : OP_HOLD;
    assign q_exp_d  = jk_next_q(q_exp_q, jk_drive);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            q_exp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_exp_q <= q_exp_d;
        end
    end

    assign j     = jk_drive[1];
    assign k     = jk_drive[0];
    assign done  = done_c;
    assign busy  = (state_q == ST_DRIVE) || !fifo_empty;
    assign q_exp = q_exp_q;

`ifdef JK_SEQ_CHECK_EN
    logic mismatch_q, mismatch_d;

    // Sticky: any divergence of the real flop from the model is latched.
    assign mismatch_d = mismatch_q | (q_fb != q_exp_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    // No feedback port, so no compare logic in this build.
`endif

endmodule

// File: tb/tb_jk_op_sequencer.sv
// Directed bench for jk_op_sequencer; feedback section active when
// JK_SEQ_CHECK_EN is defined.
module tb_jk_op_sequencer;
    import jk_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [1:0]       in_op = 2'b00;
    logic [CNT_W-1:0] in_count = '0;
    logic             in_ready;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
    logic             q_exp;

    int checks = 0;
    int errors = 0;

`ifdef JK_SEQ_CHECK_EN
    logic q_fb;
    logic mismatch;
    logic ff_q;
    logic inv = 1'b0;

    always @(posedge clk) begin
        if (!rst) ff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end
    assign q_fb = ff_q ^ inv;
`endif

    always #5 clk = ~clk;

    jk_op_sequencer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_count (in_count),
        .j        (j),
        .k        (k),
        .busy     (busy),
        .done     (done),
        .q_exp    (q_exp)
`ifdef JK_SEQ_CHECK_EN
       ,.q_fb     (q_fb),
        .mismatch (mismatch)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [1:0] op, input logic [CNT_W-1:0] c);
        in_valid = 1'b1;
        in_op    = op;
        in_count = c;
    endtask

    logic [1:0] jk_seq2 [6] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00};
    logic       q_seq2  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       dn_seq2 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] op3     [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [3:0] cnt3    [4] = '{4'd0, 4'd0, 4'd0, 4'd1};
    logic [1:0] jk_seq3 [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b01};
    logic       dn_seq3 [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int w;
        int n;
        int dn;

        // reset
        repeat (3) step();
        check("rst_ready", {7'd0, in_ready}, 8'd1);
        check("rst_jk", {6'd0, j, k}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_qexp", {7'd0, q_exp}, 8'd0);
        rst = 1'b1;
        step();

        // single SET, count 0
        set_op(2'b10, 4'd0);
        step();
        in_valid = 1'b0;
        check("t1_lat_jk", {6'd0, j, k}, 8'h00);
        check("t1_lat_busy", {7'd0, busy}, 8'd1);
        step();
        check("t1_jk", {6'd0, j, k}, 8'h02);
        check("t1_done", {7'd0, done}, 8'd1);
        check("t1_q_before", {7'd0, q_exp}, 8'd0);
        step();
        check("t1_jk_after", {6'd0, j, k}, 8'h00);
        check("t1_done_after", {7'd0, done}, 8'd0);
        check("t1_qexp", {7'd0, q_exp}, 8'd1);
        check("t1_busy", {7'd0, busy}, 8'd0);

        // RESET c1, TOGGLE c2, HOLD c0 back-to-back
        set_op(2'b01, 4'd1);
        step();
        set_op(2'b11, 4'd2);
        step();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) check("t2_q", {7'd0, q_exp}, {7'd0, q_seq2[i-1]});
            check("t2_jk", {6'd0, j, k}, {6'd0, jk_seq2[i]});
            check("t2_done", {7'd0, done}, {7'd0, dn_seq2[i]});
            if (i == 0) set_op(2'b00, 4'd0);
            if (i == 1) in_valid = 1'b0;
            step();
        end
        check("t2_q_last", {7'd0, q_exp}, {7'd0, q_seq2[5]});
        check("t2_jk_end", {6'd0, j, k}, 8'h00);
        check("t2_busy_end", {7'd0, busy}, 8'd0);

        // fill FIFO behind a long HOLD
        set_op(2'b00, 4'd15);
        step();
        in_valid = 1'b0;
        step();
        check("t3_busy", {7'd0, busy}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            set_op(op3[i], cnt3[i]);
            step();
        end
        check("t3_full", {7'd0, in_ready}, 8'd0);
        set_op(2'b01, 4'd0);
        w = 0;
        while (!in_ready && w < 30) begin
            step();
            w++;
        end
        check("t3_stall", 8'(w), 8'd12);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) in_valid = 1'b0;
            check("t3_jk", {6'd0, j, k}, {6'd0, jk_seq3[i]});
            check("t3_done", {7'd0, done}, {7'd0, dn_seq3[i]});
            step();
        end
        check("t3_jk_end", {6'd0, j, k}, 8'h00);
        check("t3_busy_end", {7'd0, busy}, 8'd0);
        check("t3_qexp", {7'd0, q_exp}, 8'd0);

        // TOGGLE with max count
        set_op(2'b11, 4'd15);
        step();
        in_valid = 1'b0;
        step();
        n = 0;
        dn = 0;
        while (j && k && n < 40) begin
            if (done) dn++;
            step();
            n++;
        end
        check("t4_cycles", 8'(n), 8'd16);
        check("t4_dones", 8'(dn), 8'd1);
        check("t4_qexp", {7'd0, q_exp}, 8'd0);
        check("t4_busy", {7'd0, busy}, 8'd0);

        // reset mid-DRIVE with two queued
        set_op(2'b10, 4'd15);
        step();
        set_op(2'b11, 4'd0);
        step();
        set_op(2'b01, 4'd0);
        step();
        in_valid = 1'b0;
        step();
        check("t5_pre_jk", {6'd0, j, k}, 8'h02);
        check("t5_pre_q", {7'd0, q_exp}, 8'd1);
        rst = 1'b0;
        step();
        check("t5_jk", {6'd0, j, k}, 8'h00);
        check("t5_busy", {7'd0, busy}, 8'd0);
        check("t5_qexp", {7'd0, q_exp}, 8'd0);
        check("t5_ready", {7'd0, in_ready}, 8'd1);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_flushed", {6'd0, j, k, busy}, 8'h00);
        end

`ifdef JK_SEQ_CHECK_EN
        // random ops against a flop model, then a forced miscompare
        for (int i = 0; i < 16; i++) begin
            set_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            step();
        end
        in_valid = 1'b0;
        w = 0;
        while (busy && w < 200) begin
            step();
            w++;
        end
        check("t6_drain", {7'd0, busy}, 8'd0);
        check("t6_model", {7'd0, q_exp}, {7'd0, ff_q});
        check("t6_no_mm", {7'd0, mismatch}, 8'd0);
        inv = 1'b1;
        step();
        inv = 1'b0;
        check("t6_mm_set", {7'd0, mismatch}, 8'd1);
        repeat (3) step();
        check("t6_mm_sticky", {7'd0, mismatch}, 8'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t6_mm_clr", {7'd0, mismatch}, 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached before summary");
        $fatal(1, "timeout");
    end

endmodule
